// File: rtl/gmii_pkg.sv
// rtl/gmii_pkg.sv - shared GMII TX types, framing constants and byte-wide CRC-32 step
package gmii_pkg;

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

  // Ethernet order: register kept reflected, data consumed LSB first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC32_POLY_REFL : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_tx_framer_if.sv
// rtl/gmii_tx_framer_if.sv - payload byte stream handshake into the framer
interface gmii_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/gmii_crc32_d8.sv
// rtl/gmii_crc32_d8.sv - byte-wide CRC-32 register with sync clear and enable
module gmii_crc32_d8
  import gmii_pkg::*;
(
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      crc_q <= CRC32_INIT;
    end else if (en_i) begin
      crc_q <= crc32_d8(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII TX framer: preamble, SFD, payload, IFG, underrun handling
// Define GMII_TX_FCS_EN to add MIN_FRAME padding and the CRC-32 FCS.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int unsigned IFG_BYTES = 12,
  parameter int unsigned MIN_FRAME = 60
) (
  input  logic            clk125_i,
  input  logic            reset_i,
  gmii_tx_framer_if.slave s_if,
  output logic [7:0]      Txd_o,
  output logic            Tx_en_o,
  output logic            Tx_er_o,
  output logic            busy_o,
  output logic            underrun_o,
  output logic [15:0]     frame_cnt_o
);

  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  state_e      state_q;
  logic [7:0]  aux_q;
  logic [7:0]  txd_q;
  logic        tx_en_q;
  logic        tx_er_q;
  logic        underrun_q;
  logic [15:0] frame_cnt_q;

`ifdef GMII_TX_FCS_EN
  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);

  logic [10:0] cnt_q;
  logic [10:0] cnt_inc;
  logic [31:0] crc;
  logic        crc_clr;
  logic        crc_en;
  logic [7:0]  crc_din;

  assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  assign crc_clr = reset_i || (state_q == PRE);
  assign crc_en  = ((state_q == DATA) && s_if.s_valid) || (state_q == PAD);
  assign crc_din = (state_q == PAD) ? 8'h00 : s_if.s_data;

  gmii_crc32_d8 u_crc (
    .clk_i  (clk125_i),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (crc_din),
    .crc_o  (crc)
  );
`endif

  // Outputs lag the state by one cycle: each register holds what the previous state drove.
  always_ff @(posedge clk125_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      aux_q       <= '0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
`ifdef GMII_TX_FCS_EN
      cnt_q       <= '0;
`endif
    end else begin
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      underrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_if.s_valid) begin
            state_q <= PRE;
            aux_q   <= '0;
          end
        end
        PRE: begin
          txd_q   <= PREAMBLE_BYTE;
          tx_en_q <= 1'b1;
          aux_q   <= aux_q + 8'd1;
          if (aux_q == 8'd6) state_q <= SFD;
        end
        SFD: begin
          txd_q   <= SFD_BYTE;
          tx_en_q <= 1'b1;
          state_q <= DATA;
`ifdef GMII_TX_FCS_EN
          cnt_q   <= '0;
`endif
        end
        DATA: begin
          tx_en_q <= 1'b1;
          if (s_if.s_valid) begin
            txd_q <= s_if.s_data;
`ifdef GMII_TX_FCS_EN
            cnt_q <= cnt_inc;
            if (s_if.s_last) begin
              aux_q   <= '0;
              state_q <= (cnt_inc < MIN_CNT) ? PAD : FCS;
            end
`else
            if (s_if.s_last) begin
              aux_q       <= '0;
              state_q     <= IFG;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end
`endif
          end else begin
            tx_er_q    <= 1'b1;
            underrun_q <= 1'b1;
            state_q    <= DRAIN;
          end
        end
`ifdef GMII_TX_FCS_EN
        PAD: begin
          tx_en_q <= 1'b1;
          cnt_q   <= cnt_inc;
          if (cnt_inc >= MIN_CNT) begin
            aux_q   <= '0;
            state_q <= FCS;
          end
        end
        FCS: begin
          txd_q   <= ~crc[{aux_q[1:0], 3'b000} +: 8];
          tx_en_q <= 1'b1;
          aux_q   <= aux_q + 8'd1;
          if (aux_q[1:0] == 2'd3) begin
            aux_q       <= '0;
            state_q     <= IFG;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
`endif
        IFG: begin
          aux_q <= aux_q + 8'd1;
          if (aux_q == IFG_LAST) begin
            aux_q   <= '0;
            state_q <= s_if.s_valid ? PRE : IDLE;
          end
        end
        DRAIN: begin
          if (s_if.s_valid && s_if.s_last) begin
            aux_q   <= '0;
            state_q <= IFG;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_if.s_ready = !reset_i && ((state_q == DATA) || (state_q == DRAIN));
  assign busy_o       = !reset_i && (state_q != IDLE);
  assign Txd_o        = txd_q;
  assign Tx_en_o      = tx_en_q;
  assign Tx_er_o      = tx_er_q;
  assign underrun_o   = underrun_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 Parameter IFG_BYTES, default 12: idle cycles forced between frames (Tx_en_o low), legal range 12..255.
REQ-002 Parameter MIN_FRAME, default 60: minimum bytes (data plus pad) before the FCS.
REQ-003 clk125_i  in  1  sole clock, 125 MHz, the same clock that drives Gtx_clk_i of the RGMII converter.
REQ-004 reset_i  in  1  reset, synchronous to clk125_i, active-high.
REQ-005 s_data_i  in  8  payload byte (destination MAC onward, no preamble).
REQ-006 s_valid_i  in  1  s_data_i valid.
REQ-007 s_last_i  in  1  marks the final payload byte; qualified by s_valid_i.
REQ-008 s_ready_o  out  1  framer accepts s_data_i this cycle.
REQ-009 Txd_o  out  8  GMII transmit data to the RGMII converter.
REQ-010 Tx_en_o  out  1  GMII transmit enable.
REQ-011 Tx_er_o  out  1  GMII transmit error.
REQ-012 busy_o  out  1  high in every state except IDLE.
REQ-013 underrun_o  out  1  one-cycle pulse when an underrun is detected.
REQ-014 frame_cnt_o  out  16  count of frames fully transmitted; wraps 0xFFFF->0x0000.

Function
REQ-015 FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN.
REQ-016 Txd_o, Tx_en_o and Tx_er_o are registered; each state's values appear on the cycle after the state is entered.
REQ-017 IDLE: s_ready_o=0; s_valid_i=1 -> PRE next cycle, so Tx_en_o rises 1 cycle after the first s_valid_i sample.
REQ-018 PRE drives 0x55 for 7 cycles with Tx_en_o=1; SFD then drives 0xD5 for 1 cycle.
REQ-019 DATA: s_ready_o=1 combinationally; a byte accepted on s_valid_i&s_ready_o drives Txd_o on the next cycle with Tx_en_o=1.
REQ-020 DATA byte counter is 11 bits and saturates at 2047; the framer enforces no maximum length.
REQ-021 Byte accepted with s_last_i=1 -> PAD if count<MIN_FRAME, else FCS (FCS_EN defined) or IFG (undefined).
REQ-022 PAD drives 0x00 until the data-plus-pad count equals MIN_FRAME, then enters FCS.
REQ-023 FCS: CRC-32 with polynomial 0x04C11DB7 (reflected), init 0xFFFFFFFF, result complemented.
REQ-024 FCS covers the data and pad bytes only, never preamble or SFD.
REQ-025 FCS is sent in 4 cycles, ~crc[7:0] first and ~crc[31:24] last.
REQ-026 Underrun is s_valid_i=0 in DATA: next cycle Txd_o=0x00, Tx_en_o=1, Tx_er_o=1 for exactly 1 cycle, and underrun_o pulses.
REQ-027 After an underrun the FSM enters DRAIN; frame_cnt_o does not increment.
REQ-028 DRAIN: s_ready_o=1; input bytes are discarded until s_valid_i&s_last_i, then the FSM enters IFG.
REQ-029 IFG: Tx_en_o=0, Txd_o=0x00, s_ready_o=0 for IFG_BYTES cycles, then IDLE.
REQ-030 Back-to-back frames: s_valid_i held high through IFG -> PRE on the cycle after IFG ends; Tx_en_o low for exactly IFG_BYTES cycles.
REQ-031 frame_cnt_o increments on entry to IFG from FCS, or from DATA when FCS_EN is undefined.
REQ-032 A frame with a single byte carrying s_last_i=1 is legal: it is padded to MIN_FRAME.
REQ-033 Tx_er_o=0 in all cases other than the underrun cycle.

Reset
REQ-034 reset_i=1 forces IDLE, clears the byte counter, CRC register and IFG counter, and sets frame_cnt_o=0.
REQ-035 While reset_i=1: Txd_o=0x00, Tx_en_o=0, Tx_er_o=0, s_ready_o=0, busy_o=0, underrun_o=0.
REQ-036 Reset mid-frame truncates the frame immediately (Tx_en_o low on the next cycle) with no error cycle and no count increment.

Configuration
REQ-037 Macro GMII_TX_FCS_EN defined: PAD and FCS states, CRC logic and MIN_FRAME padding are present.
REQ-038 Macro GMII_TX_FCS_EN undefined: PAD and FCS states and CRC logic are compiled out.
REQ-039 With GMII_TX_FCS_EN undefined, the payload (which then includes the user-supplied FCS) goes straight from DATA to IFG with no padding.

Structure
REQ-040 Shared package gmii_pkg holds: the state enum, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC32_POLY, CRC32_INIT, and the byte-wide CRC next-state function.
REQ-041 One sub-module, gmii_crc32_d8: byte-wide CRC with sync clear and enable inputs, reused by a future RX checker.

Verification
REQ-042 Single 64-byte frame 0x00..0x3F, FCS_EN on -> 7x0x55, 0xD5, 64 data bytes, 4 FCS bytes matching the bench CRC model; Tx_en_o high 76 cycles; frame_cnt_o=1.
REQ-043 1-byte frame 0xAA -> 0xAA followed by 59 bytes 0x00 then the FCS; Tx_en_o high 72 cycles.
REQ-044 Two 60-byte frames with s_valid_i continuously high -> Tx_en_o low for exactly 12 cycles between them; frame_cnt_o=2.
REQ-045 s_valid_i dropped after byte 20 of 64 -> 1 cycle of Tx_er_o=1 with Tx_en_o=1; underrun_o pulses; remaining bytes drained; frame_cnt_o unchanged; next frame is clean.
REQ-046 reset_i asserted during FCS byte 2 -> Tx_en_o=0 the next cycle; all outputs at reset values; a following frame transmits normally.
REQ-047 FCS_EN undefined with ASCII "123456789" plus appended FCS 0x26,0x39,0xF4,0xCB -> 13 bytes emitted unmodified after the SFD; no pad.
